// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the memory pipeline stage and its load-extend helper.
// Contains the load-op one-hot bit positions and the exception bundle layout.
package cpu_pkg;

  // Bit positions inside the one-hot load op {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_OP_W = 5;
  localparam int LD_B    = 4;
  localparam int LD_BU   = 3;
  localparam int LD_H    = 2;
  localparam int LD_HU   = 1;
  localparam int LD_W    = 0;

  localparam int EXCP_W         = 82;
  localparam int EXCP_VALID_BIT = 0;

endpackage

// File: rtl/load_extend.sv
// Aligns a 32-bit read word by the low address bits and applies byte/half/word
// extraction with sign or zero extension. Purely combinational.
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0]        rdata_i,
  input  logic [1:0]         addr_i,
  input  logic [LD_OP_W-1:0] ld_op_i,
  output logic [31:0]        result_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {addr_i, 3'b000};

  // NOTE: result_o gets a default before the if-chain so no path leaves it unassigned (no latch).
  always_comb begin
    result_o = rdata_i;
    if (ld_op_i[LD_B]) begin
      result_o = {{24{shifted[7]}}, shifted[7:0]};
    end else if (ld_op_i[LD_BU]) begin
      result_o = {24'h0, shifted[7:0]};
    end else if (ld_op_i[LD_H]) begin
      result_o = {{16{shifted[15]}}, shifted[15:0]};
    end else if (ld_op_i[LD_HU]) begin
      result_o = {16'h0, shifted[15:0]};
    end else if (ld_op_i[LD_W]) begin
      result_o = shifted;
    end
  end

endmodule

// File: rtl/mem_resp_stage.sv
// MEM pipeline stage for a split-transaction data bus: tracks in-flight requests,
// holds the instruction until its response arrives, buffers or discards responses.
module mem_resp_stage
  import cpu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int EXCP_W          = cpu_pkg::EXCP_W,
  parameter int PC_W            = 32
) (
  input  logic              clk,
  input  logic              reset,
  // EX -> MEM
  input  logic              es2ms_valid,
  output logic              ms_allowin,
  input  logic [PC_W-1:0]   es_pc,
  input  logic [31:0]       es_alu_result,
  input  logic              es_rf_we,
  input  logic              es_res_from_mem,
  input  logic              es_csr_re,
  input  logic [4:0]        es_rf_waddr,
  input  logic [LD_OP_W-1:0] es_ld_op,
  input  logic              es_mem_req,
  input  logic [EXCP_W-1:0] es_except,
  input  logic              data_req_fire,
  output logic              ms_req_allow,
  // data bus response
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  // MEM -> WB
  input  logic              ws_allowin,
  output logic              ms2ws_valid,
  output logic [PC_W-1:0]   ms_pc,
  output logic [EXCP_W-1:0] ms_except,
  output logic              ms_rf_we,
  output logic [4:0]        ms_rf_waddr,
  output logic [31:0]       ms_rf_wdata,
  // bypass / hazard info to ID
  output logic              ms_fwd_we,
  output logic              ms_fwd_stall,
  output logic              ms_csr_re_o,
  output logic              ms_ex,
  input  logic              wb_ex
);

  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  logic                 ms_valid_q;
  logic [PC_W-1:0]      pc_q;
  logic [31:0]          alu_result_q;
  logic                 rf_we_q;
  logic                 res_from_mem_q;
  logic                 csr_re_q;
  logic [4:0]           rf_waddr_q;
  logic [LD_OP_W-1:0]   ld_op_q;
  logic                 mem_req_q;
  logic [EXCP_W-1:0]    except_q;

  logic [2:0]           outstanding_q, outstanding_d;
  logic [2:0]           discard_q, discard_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [31:0]          buf_data_q, buf_data_d;

  logic                 need_data;
  logic                 data_ok_live;
  logic                 ms_ready_go;
  logic                 load_stage;
  logic                 move_to_wb;
  logic                 buf_write;
  logic [31:0]          ld_rdata;
  logic [31:0]          ld_result;

  assign need_data    = mem_req_q & ~except_q[EXCP_VALID_BIT];
  // A response counts for this instruction only when no flushed responses are pending.
  assign data_ok_live = data_sram_data_ok & (discard_q == 3'd0);
  assign ms_ready_go  = ~need_data | buf_valid_q | data_ok_live;
  assign ms_allowin   = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign load_stage   = es2ms_valid & ms_allowin;
  assign ms2ws_valid  = ms_valid_q & ms_ready_go;
  assign move_to_wb   = ms2ws_valid & ws_allowin;
  assign buf_write    = data_ok_live & ms_valid_q & need_data & ~buf_valid_q & ~ws_allowin;

  assign ms_req_allow = (outstanding_q < MAX_OUT) & (discard_q == 3'd0);

  always_comb begin
    outstanding_d = outstanding_q;
    // Responses to requests issued before a reset are not tracked, so never underflow.
    if (data_req_fire && !(data_sram_data_ok && outstanding_q != 3'd0)) begin
      outstanding_d = outstanding_q + 3'd1;
    end else if (!data_req_fire && data_sram_data_ok && outstanding_q != 3'd0) begin
      outstanding_d = outstanding_q - 3'd1;
    end

    discard_d = discard_q;
    if (wb_ex) begin
      discard_d = outstanding_d;
    end else if (data_sram_data_ok && discard_q != 3'd0) begin
      discard_d = discard_q - 3'd1;
    end

    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (wb_ex || move_to_wb) begin
      buf_valid_d = 1'b0;
    end else if (buf_write) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end
  end

  // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q     <= 1'b0;
      pc_q           <= '0;
      alu_result_q   <= '0;
      rf_we_q        <= 1'b0;
      res_from_mem_q <= 1'b0;
      csr_re_q       <= 1'b0;
      rf_waddr_q     <= '0;
      ld_op_q        <= '0;
      mem_req_q      <= 1'b0;
      except_q       <= '0;
      outstanding_q  <= '0;
      discard_q      <= '0;
      buf_valid_q    <= 1'b0;
      buf_data_q     <= '0;
    end else begin
      if (wb_ex) begin
        ms_valid_q <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid_q <= es2ms_valid;
      end
      if (load_stage) begin
        pc_q           <= es_pc;
        alu_result_q   <= es_alu_result;
        rf_we_q        <= es_rf_we;
        res_from_mem_q <= es_res_from_mem;
        csr_re_q       <= es_csr_re;
        rf_waddr_q     <= es_rf_waddr;
        ld_op_q        <= es_ld_op;
        mem_req_q      <= es_mem_req;
        except_q       <= es_except;
      end
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      buf_valid_q   <= buf_valid_d;
      buf_data_q    <= buf_data_d;
    end
  end

  assign ld_rdata = buf_valid_q ? buf_data_q : data_sram_rdata;

  load_extend u_load_extend (
    .rdata_i  (ld_rdata),
    .addr_i   (alu_result_q[1:0]),
    .ld_op_i  (ld_op_q),
    .result_o (ld_result)
  );

  assign ms_pc        = pc_q;
  assign ms_except    = except_q;
  assign ms_rf_we     = rf_we_q;
  assign ms_rf_waddr  = rf_waddr_q;
  assign ms_rf_wdata  = res_from_mem_q ? ld_result : alu_result_q;
  assign ms_fwd_we    = ms_valid_q & rf_we_q;
  assign ms_fwd_stall = ms_valid_q & res_from_mem_q & need_data & ~buf_valid_q & ~data_ok_live;
  assign ms_csr_re_o  = ms_valid_q & csr_re_q;
  assign ms_ex        = ms_valid_q & except_q[EXCP_VALID_BIT];

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed bench for mem_resp_stage: inputs change on the falling edge, outputs
// are compared 1 ns later, well away from the rising edge.
module tb_mem_resp_stage;

  localparam int EXCP_W = 82;
  localparam int PC_W   = 32;

  localparam logic [4:0] OP_B  = 5'b10000;
  localparam logic [4:0] OP_BU = 5'b01000;
  localparam logic [4:0] OP_W  = 5'b00001;

  logic              clk = 1'b0;
  logic              reset;
  logic              es2ms_valid;
  logic              ms_allowin;
  logic [PC_W-1:0]   es_pc;
  logic [31:0]       es_alu_result;
  logic              es_rf_we, es_res_from_mem, es_csr_re;
  logic [4:0]        es_rf_waddr;
  logic [4:0]        es_ld_op;
  logic              es_mem_req;
  logic [EXCP_W-1:0] es_except;
  logic              data_req_fire;
  logic              ms_req_allow;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              ws_allowin;
  logic              ms2ws_valid;
  logic [PC_W-1:0]   ms_pc;
  logic [EXCP_W-1:0] ms_except;
  logic              ms_rf_we;
  logic [4:0]        ms_rf_waddr;
  logic [31:0]       ms_rf_wdata;
  logic              ms_fwd_we, ms_fwd_stall, ms_csr_re_o, ms_ex;
  logic              wb_ex;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_resp_stage #(.MAX_OUTSTANDING(2), .EXCP_W(EXCP_W), .PC_W(PC_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .es2ms_valid       (es2ms_valid),
    .ms_allowin        (ms_allowin),
    .es_pc             (es_pc),
    .es_alu_result     (es_alu_result),
    .es_rf_we          (es_rf_we),
    .es_res_from_mem   (es_res_from_mem),
    .es_csr_re         (es_csr_re),
    .es_rf_waddr       (es_rf_waddr),
    .es_ld_op          (es_ld_op),
    .es_mem_req        (es_mem_req),
    .es_except         (es_except),
    .data_req_fire     (data_req_fire),
    .ms_req_allow      (ms_req_allow),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .ms2ws_valid       (ms2ws_valid),
    .ms_pc             (ms_pc),
    .ms_except         (ms_except),
    .ms_rf_we          (ms_rf_we),
    .ms_rf_waddr       (ms_rf_waddr),
    .ms_rf_wdata       (ms_rf_wdata),
    .ms_fwd_we         (ms_fwd_we),
    .ms_fwd_stall      (ms_fwd_stall),
    .ms_csr_re_o       (ms_csr_re_o),
    .ms_ex             (ms_ex),
    .wb_ex             (wb_ex)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    es2ms_valid       = 1'b0;
    data_req_fire     = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    ws_allowin        = 1'b1;
    wb_ex             = 1'b0;
  endtask

  task automatic set_inst(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] op,
                          input logic from_mem, input logic mem_req, input logic [4:0] waddr);
    es_pc           = pc;
    es_alu_result   = alu;
    es_ld_op        = op;
    es_res_from_mem = from_mem;
    es_mem_req      = mem_req;
    es_rf_waddr     = waddr;
    es_rf_we        = 1'b1;
    es_csr_re       = 1'b0;
    es_except       = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ms2ws_valid"}, 64'(ms2ws_valid), 64'd0);
    check({tag, ".fwd_we"},      64'(ms_fwd_we),   64'd0);
    check({tag, ".fwd_stall"},   64'(ms_fwd_stall), 64'd0);
    check({tag, ".ms_ex"},       64'(ms_ex),       64'd0);
    check({tag, ".csr_re"},      64'(ms_csr_re_o), 64'd0);
    check({tag, ".allowin"},     64'(ms_allowin),  64'd1);
    check({tag, ".req_allow"},   64'(ms_req_allow), 64'd1);
  endtask

  // Load enters MEM with its request in flight; the response comes two cycles later.
  task automatic single_load(input string tag, input logic [4:0] op, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp);
    idle();
    set_inst(32'h200, addr, op, 1'b1, 1'b1, 5'd7);
    es2ms_valid   = 1'b1;
    data_req_fire = 1'b1;
    #1 check({tag, ".req_allow"}, 64'(ms_req_allow), 64'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      idle();
      #1;
      check({tag, ".wait_valid"}, 64'(ms2ws_valid), 64'd0);
      check({tag, ".wait_stall"}, 64'(ms_fwd_stall), 64'd1);
    end
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    #1;
    check({tag, ".resp_valid"}, 64'(ms2ws_valid), 64'd1);
    check({tag, ".resp_stall"}, 64'(ms_fwd_stall), 64'd0);
    check({tag, ".wdata"},      64'(ms_rf_wdata), 64'(exp));
    step();
    idle();
    #1 check({tag, ".drained"}, 64'(ms2ws_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    set_inst(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Non-memory instruction passes through in one cycle.
    set_inst(32'h100, 32'h1234, 5'd0, 1'b0, 1'b0, 5'd5);
    es2ms_valid = 1'b1;
    #1 check("alu.allowin", 64'(ms_allowin), 64'd1);
    step();
    idle();
    #1;
    check("alu.valid", 64'(ms2ws_valid), 64'd1);
    check("alu.wdata", 64'(ms_rf_wdata), 64'h1234);
    check("alu.waddr", 64'(ms_rf_waddr), 64'd5);
    check("alu.pc",    64'(ms_pc),       64'h100);
    check("alu.fwd_we", 64'(ms_fwd_we),  64'd1);
    check("alu.stall", 64'(ms_fwd_stall), 64'd0);
    step();
    #1 check("alu.drained", 64'(ms2ws_valid), 64'd0);

    single_load("ldb",  OP_B,  32'h1003, 32'h80FF_FF00, 32'hFFFF_FF80);
    single_load("ldbu", OP_BU, 32'h1003, 32'h80FF_FF00, 32'h0000_0080);

    // Response arrives while WB is stalled: it is buffered and released later.
    idle();
    set_inst(32'h300, 32'h2000, OP_W, 1'b1, 1'b1, 5'd9);
    es2ms_valid   = 1'b1;
    data_req_fire = 1'b1;
    step();
    idle();
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1 check("buf.allowin", 64'(ms_allowin), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      idle();
      ws_allowin      = 1'b0;
      data_sram_rdata = 32'h5555_AAAA;
      #1;
      check("buf.held_valid", 64'(ms2ws_valid), 64'd1);
      check("buf.held_wdata", 64'(ms_rf_wdata), 64'hDEAD_BEEF);
      check("buf.held_stall", 64'(ms_fwd_stall), 64'd0);
    end
    step();
    idle();
    #1;
    check("buf.release_valid", 64'(ms2ws_valid), 64'd1);
    check("buf.release_wdata", 64'(ms_rf_wdata), 64'hDEAD_BEEF);
    step();
    #1;
    check("buf.drained",   64'(ms2ws_valid),  64'd0);
    check("buf.req_allow", 64'(ms_req_allow), 64'd1);

    // Two loads in flight: issue is throttled, responses go to the right instruction.
    idle();
    set_inst(32'h400, 32'h10, OP_W, 1'b1, 1'b1, 5'd1);
    es2ms_valid   = 1'b1;
    data_req_fire = 1'b1;
    step();
    set_inst(32'h404, 32'h14, OP_W, 1'b1, 1'b1, 5'd2);
    #1 check("b2b.req_allow_1", 64'(ms_req_allow), 64'd1);
    step();
    data_req_fire = 1'b0;
    #1 check("b2b.req_allow_2", 64'(ms_req_allow), 64'd0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    #1;
    check("b2b.first_valid", 64'(ms2ws_valid), 64'd1);
    check("b2b.first_wdata", 64'(ms_rf_wdata), 64'h1111_1111);
    check("b2b.first_waddr", 64'(ms_rf_waddr), 64'd1);
    check("b2b.allowin",     64'(ms_allowin),  64'd1);
    step();
    idle();
    #1;
    check("b2b.second_wait",  64'(ms2ws_valid),  64'd0);
    check("b2b.second_stall", 64'(ms_fwd_stall), 64'd1);
    check("b2b.req_allow_3",  64'(ms_req_allow), 64'd1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h2222_2222;
    #1;
    check("b2b.second_wdata", 64'(ms_rf_wdata), 64'h2222_2222);
    check("b2b.second_waddr", 64'(ms_rf_waddr), 64'd2);
    step();
    idle();
    #1 check("b2b.drained", 64'(ms2ws_valid), 64'd0);

    // Flush with two requests in flight: both responses are dropped.
    set_inst(32'h500, 32'h20, OP_W, 1'b1, 1'b1, 5'd3);
    es2ms_valid   = 1'b1;
    data_req_fire = 1'b1;
    step();
    set_inst(32'h504, 32'h24, OP_W, 1'b1, 1'b1, 5'd4);
    step();
    idle();
    wb_ex = 1'b1;
    step();
    idle();
    #1;
    check("flush.valid",      64'(ms2ws_valid),  64'd0);
    check("flush.fwd_we",     64'(ms_fwd_we),    64'd0);
    check("flush.req_allow0", 64'(ms_req_allow), 64'd0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hAAAA_0001;
    step();
    #1 check("flush.req_allow1", 64'(ms_req_allow), 64'd0);
    data_sram_rdata = 32'hAAAA_0002;
    step();
    idle();
    #1 check("flush.req_allow2", 64'(ms_req_allow), 64'd1);
    set_inst(32'h508, 32'h30, OP_W, 1'b1, 1'b1, 5'd6);
    es2ms_valid   = 1'b1;
    data_req_fire = 1'b1;
    step();
    idle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h3333_3333;
    #1;
    check("flush.third_valid", 64'(ms2ws_valid), 64'd1);
    check("flush.third_wdata", 64'(ms_rf_wdata), 64'h3333_3333);
    check("flush.third_pc",    64'(ms_pc),       64'h508);
    step();
    idle();

    // Asynchronous reset in the middle of a wait.
    set_inst(32'h600, 32'h40, OP_W, 1'b1, 1'b1, 5'd8);
    es2ms_valid   = 1'b1;
    data_req_fire = 1'b1;
    step();
    idle();
    #1 check("areset.pre_stall", 64'(ms_fwd_stall), 64'd1);
    #1 reset = 1'b1;
    #1 check_reset_outputs("areset");
    @(negedge clk);
    reset = 1'b0;
    #1 check("areset.after", 64'(ms2ws_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_resp_stage.md
Name: mem_resp_stage

Overview:
- Parametrised MEM pipeline stage between EX and WB for a split-transaction data bus (address accepted in EX, data returned later with data_ok).
- Tracks in-flight data requests and stalls the instruction until its response arrives.
- Buffers responses that arrive while WB is stalled, discards responses of flushed instructions, and performs load byte/half extraction and extension.
- Supplies bypass/stall info to ID and throttles EX request issue.

Parameters:
- MAX_OUTSTANDING, 2, max data requests in flight (1..7); counters are 3 bits wide.
- EXCP_W, 82, exception bundle width; bit 0 = "exception present" flag.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- es2ms_valid  in  1  EX holds a valid instruction for MEM
- ms_allowin  out  1  MEM can accept from EX
- es_pc  in  PC_W  instruction PC
- es_alu_result  in  32  ALU result / load address
- es_rf_we, es_res_from_mem, es_csr_re  in  1 each  writeback controls
- es_rf_waddr  in  5  destination register
- es_ld_op  in  5  one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}
- es_mem_req  in  1  instruction issued an accepted data request (load or store)
- es_except  in  EXCP_W  exception bundle
- data_req_fire  in  1  EX data request handshake completed this cycle
- ms_req_allow  out  1  EX may issue a new data request
- data_sram_data_ok  in  1  response valid
- data_sram_rdata  in  32  response data
- ws_allowin  in  1  WB can accept
- ms2ws_valid  out  1  valid to WB
- ms_pc  out  PC_W; ms_except  out  EXCP_W; ms_rf_we  out  1; ms_rf_waddr  out  5; ms_rf_wdata  out  32
- ms_fwd_we  out  1  bypass write-enable (ms_valid & ms_rf_we)
- ms_fwd_stall  out  1  bypass data not ready (load waiting for data)
- ms_csr_re_o  out  1  ms_valid & csr_re
- ms_ex  out  1  ms_valid & ms_except[0]
- wb_ex  in  1  flush from WB

Behaviour:
- Reset: ms_valid=0, outstanding=0, discard=0, buf_valid=0, all stage registers 0. Outputs therefore: ms2ws_valid=0, ms_fwd_we=0, ms_fwd_stall=0, ms_ex=0, ms_csr_re_o=0, ms_allowin=1, ms_req_allow=1.
- Handshake:
  - ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
  - Stage registers load on es2ms_valid & ms_allowin.
  - ms_valid <= es2ms_valid when ms_allowin.
  - wb_ex clears ms_valid (priority over load).
- Outstanding counter:
  - +1 on data_req_fire; -1 on data_sram_data_ok; both in one cycle means no change.
  - ms_req_allow = (outstanding < MAX_OUTSTANDING) & (discard == 0).
- Wait state, per instruction:
  - need_data = ms_mem_req & ~ms_except[0].
  - ms_ready_go = ~need_data | buf_valid | (data_ok & discard==0).
  - A store also waits for its data_ok.
  - An instruction with an exception does not wait.
- Response buffer, 1 entry:
  - Written when data_ok & discard==0 & ms_valid & need_data & ~buf_valid & ~ws_allowin.
  - Cleared when the instruction moves to WB or on wb_ex.
  - Load data comes from the buffer when buf_valid, else from data_sram_rdata.
- Discard counter:
  - On wb_ex: discard <= outstanding_next − (1 if buf_valid else 0 is already consumed, so no adjustment), i.e. the count of in-flight requests after this cycle's inc/dec.
  - Otherwise decrement on data_ok while discard>0; such responses are dropped.
  - A response arriving in the same cycle as wb_ex is consumed by the flush, not counted.
- Load extract:
  - shift = rdata >> {addr[1:0],3'b0}.
  - ld_b/ld_h sign-extend; ld_bu/ld_hu zero-extend; ld_w passes through.
  - ms_rf_wdata = res_from_mem ? load result : alu_result.
- ms_fwd_stall = ms_valid & es_res_from_mem latched & need_data & ~buf_valid & ~(data_ok & discard==0).
- ms2ws_valid = ms_valid & ms_ready_go; it never asserts during wb_ex's cycle effect next cycle.
- Reset mid-transaction clears everything asynchronously; responses to pre-reset requests are not tracked.

Decomposition:
- Shared package (cpu_pkg):
  - ld_op one-hot index constants (LD_B..LD_W).
  - EXCP_W.
  - Exception-present bit index.
- One sub-module, load_extend: combinational rdata + addr[1:0] + ld_op → 32-bit result. Reused later by the cache path.

Test Plan:
- Non-memory inst (alu_result 0x1234, rf_we=1, waddr=5): ms2ws_valid the cycle after acceptance, wdata 0x1234, no stall.
- ld_b at address offset 3, rdata 0x80FF_FF00, data_ok 2 cycles after entry: ms2ws_valid stays 0 and fwd_stall stays 1 until data_ok; wdata 0xFFFF_FF80. The same case with ld_bu gives 0x0000_0080.
- Load data_ok while ws_allowin=0 for 3 cycles: response buffered; released with correct data once ws_allowin=1; no second data_ok is consumed.
- Two loads issued back-to-back (MAX_OUTSTANDING=2): ms_req_allow drops to 0 with 2 in flight; responses are delivered in order to the correct instructions.
- wb_ex with 2 requests in flight: ms_valid clears; the next 2 data_ok are dropped; a subsequent load gets the 3rd response; ms_req_allow is low until discard reaches 0.
- Async reset asserted mid-wait: all outputs go to reset values immediately, without waiting for a clock edge.
